// File: rtl/rng_roll_capture_if.sv
// Bundles the PRNG stream, the user controls and the display/status outputs
// of the roll-capture block. The slave side is the capture block itself.
interface rng_roll_capture_if;
  logic [7:0] rnd_in;
  logic       rnd_valid;
  logic       btn_roll;
  logic       hold_mode;
  logic [1:0] sel_hist;
  logic [7:0] disp_byte;
  logic [7:0] roll_count;
  logic       busy;
  logic       err;
  logic       capture_pulse;

  modport slave (
    input  rnd_in, rnd_valid, btn_roll, hold_mode, sel_hist,
    output disp_byte, roll_count, busy, err, capture_pulse
  );

  modport master (
    output rnd_in, rnd_valid, btn_roll, hold_mode, sel_hist,
    input  disp_byte, roll_count, busy, err, capture_pulse
  );
endinterface

// File: rtl/rng_roll_capture.sv
// Captures the next fresh PRNG byte on a debounced roll press into a 4-deep
// history and drives either the live byte or a history entry to the display.
//
// state       | meaning
// ST_IDLE     | waiting for a debounced roll press
// ST_WAIT_RND | armed; next rnd_valid is captured, or timeout sets err
// ST_LOCKOUT  | dead time after a capture; presses are ignored
module rng_roll_capture #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd10_000_000,
  parameter logic [15:0] LOCKOUT_CYCLES  = 16'd1_000
) (
  input  logic               CLK,
  input  logic               rst,
  rng_roll_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RND = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  localparam logic [15:0] DEB_LAST  = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [23:0] TMO_LOAD  = TIMEOUT_CYCLES - 24'd1;
  localparam logic [23:0] LOCK_LOAD = {8'd0, LOCKOUT_CYCLES - 16'd1};

  logic        r_sync1;
  logic        r_sync2;
  logic        r_deb;
  logic        r_deb_q;
  logic [15:0] r_deb_cnt;

  state_t      r_state;
  logic [23:0] r_tmr;
  logic [7:0]  r_hist [4];
  logic [1:0]  r_wr_ptr;
  logic [7:0]  r_live;
  logic [7:0]  r_roll_count;
  logic        r_busy;
  logic        r_err;
  logic        r_cap_pulse;

  logic        w_roll_req;
  logic [1:0]  w_rd_idx;

  // Counter only runs while the synced level disagrees with the accepted one.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_q   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.btn_roll;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      if (r_sync2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_deb     <= ~r_deb;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 16'd1;
      end
    end
  end

  assign w_roll_req = r_deb & ~r_deb_q;

  // r_tmr is shared: timeout budget in WAIT_RND, dead time in LOCKOUT.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_tmr        <= '0;
      r_wr_ptr     <= '0;
      r_roll_count <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_cap_pulse  <= 1'b0;
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
    end else begin
      r_cap_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_roll_req) begin
            r_state <= ST_WAIT_RND;
            r_tmr   <= TMO_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_RND: begin
          if (bus.rnd_valid) begin
            r_hist[r_wr_ptr] <= bus.rnd_in;
            r_wr_ptr         <= r_wr_ptr + 2'd1;
            r_roll_count     <= r_roll_count + 8'd1;
            r_err            <= 1'b0;
            r_cap_pulse      <= 1'b1;
            r_state          <= ST_LOCKOUT;
            r_tmr            <= LOCK_LOAD;
          end else if (r_tmr == '0) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - 24'd1;
          end
        end
        ST_LOCKOUT: begin
          if (r_tmr == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - 24'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_live <= '0;
    end else if (bus.rnd_valid) begin
      r_live <= bus.rnd_in;
    end
  end

  // Newest entry sits just behind the write pointer.
  assign w_rd_idx = r_wr_ptr - 2'd1 - bus.sel_hist;

  assign bus.disp_byte     = bus.hold_mode ? r_hist[w_rd_idx] : r_live;
  assign bus.roll_count    = r_roll_count;
  assign bus.busy          = r_busy;
  assign bus.err           = r_err;
  assign bus.capture_pulse = r_cap_pulse;

endmodule

// File: tb/tb_rng_roll_capture.sv
// Directed bench for rng_roll_capture with short debounce/timeout/lockout
// parameters so every timing boundary can be hit cycle-exactly.
module tb_rng_roll_capture;
  logic CLK = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  rng_roll_capture_if bus ();

  rng_roll_capture #(
    .DEBOUNCE_CYCLES(16'd4),
    .TIMEOUT_CYCLES (24'd8),
    .LOCKOUT_CYCLES (16'd3)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    bus.rnd_in    = 8'h00;
    bus.rnd_valid = 1'b0;
    bus.btn_roll  = 1'b0;
    bus.hold_mode = 1'b0;
    bus.sel_hist  = 2'd0;
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
  endtask

  task automatic press_wait_busy();
    bit seen = 1'b0;
    bus.btn_roll = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus.busy === 1'b1) seen = 1'b1;
    end
    bus.btn_roll = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL press_busy got=0 exp=1 within 20 cycles");
    end
  endtask

  task automatic roll(input logic [7:0] v);
    press_wait_busy();
    @(negedge CLK);
    bus.rnd_in    = v;
    bus.rnd_valid = 1'b1;
    @(negedge CLK);
    bus.rnd_valid = 1'b0;
    checks++;
    if (bus.capture_pulse !== 1'b1) begin
      failures++;
      $display("FAIL roll_pulse value=%h got=%b exp=1", v, bus.capture_pulse);
    end
    repeat (12) @(negedge CLK);
  endtask

  task automatic test_reset();
    bus.rnd_in = 8'h5A; bus.rnd_valid = 1'b0; bus.btn_roll = 1'b0;
    bus.hold_mode = 1'b0; bus.sel_hist = 2'd0;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.disp_byte, bus.roll_count, bus.busy, bus.err, bus.capture_pulse} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs disp=%h cnt=%h busy=%b err=%b pulse=%b exp all 0",
               bus.disp_byte, bus.roll_count, bus.busy, bus.err, bus.capture_pulse);
    end
    bus.hold_mode = 1'b1; bus.sel_hist = 2'd2;
    #1;
    checks++;
    if (bus.disp_byte !== 8'h00) begin
      failures++;
      $display("FAIL reset_hist got=%h exp=00", bus.disp_byte);
    end
    apply_reset();
  endtask

  task automatic test_bounce();
    bit busy_seen = 1'b0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      bus.btn_roll = ((i / 2) % 2) == 0;
      @(negedge CLK);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
    end
    bus.btn_roll = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin
      failures++;
      $display("FAIL bounce_busy got=1 exp=0");
    end
    checks++;
    if (bus.roll_count !== 8'd0) begin
      failures++;
      $display("FAIL bounce_count got=%0d exp=0", bus.roll_count);
    end
  endtask

  task automatic test_clean_roll();
    apply_reset();
    bus.btn_roll = 1'b1;
    repeat (6) @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL clean_busy_early got=%b exp=0", bus.busy);
    end
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_busy_rise got=%b exp=1", bus.busy);
    end
    bus.btn_roll = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    bus.rnd_in = 8'hA5; bus.rnd_valid = 1'b1; bus.hold_mode = 1'b1; bus.sel_hist = 2'd0;
    @(negedge CLK);
    bus.rnd_valid = 1'b0;
    checks++;
    if (bus.capture_pulse !== 1'b1 || bus.roll_count !== 8'd1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_capture pulse=%b cnt=%0d busy=%b exp 1/1/1",
               bus.capture_pulse, bus.roll_count, bus.busy);
    end
    checks++;
    if (bus.disp_byte !== 8'hA5) begin
      failures++;
      $display("FAIL clean_hist got=%h exp=a5", bus.disp_byte);
    end
    @(negedge CLK);
    checks++;
    if (bus.capture_pulse !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_n1 pulse=%b busy=%b exp 0/1", bus.capture_pulse, bus.busy);
    end
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_n2 busy got=%b exp=1", bus.busy);
    end
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL clean_n3 busy got=%b exp=0", bus.busy);
    end
    bus.hold_mode = 1'b0;
    #1;
    checks++;
    if (bus.disp_byte !== 8'hA5) begin
      failures++;
      $display("FAIL clean_live got=%h exp=a5", bus.disp_byte);
    end
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_history_wrap();
    logic [7:0] vals [5];
    logic [7:0] exp_h [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_h = '{8'h55, 8'h44, 8'h33, 8'h22};
    apply_reset();
    for (int i = 0; i < 5; i++) roll(vals[i]);
    bus.hold_mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bus.sel_hist = s[1:0];
      #1;
      checks++;
      if (bus.disp_byte !== exp_h[s]) begin
        failures++;
        $display("FAIL wrap_sel%0d got=%h exp=%h", s, bus.disp_byte, exp_h[s]);
      end
    end
    checks++;
    if (bus.roll_count !== 8'd5) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=5", bus.roll_count);
    end
    bus.hold_mode = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    roll(8'hA1);
    press_wait_busy();
    repeat (7) @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early busy=%b err=%b exp 1/0", bus.busy, bus.err);
    end
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_hit busy=%b err=%b exp 0/1", bus.busy, bus.err);
    end
    bus.hold_mode = 1'b1; bus.sel_hist = 2'd0;
    #1;
    checks++;
    if (bus.disp_byte !== 8'hA1 || bus.roll_count !== 8'd1) begin
      failures++;
      $display("FAIL timeout_hist disp=%h cnt=%0d exp a1/1", bus.disp_byte, bus.roll_count);
    end
    repeat (8) @(negedge CLK);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got=%b exp=1", bus.err);
    end
    roll(8'hB2);
    checks++;
    if (bus.err !== 1'b0 || bus.roll_count !== 8'd2 || bus.disp_byte !== 8'hB2) begin
      failures++;
      $display("FAIL timeout_clear err=%b cnt=%0d disp=%h exp 0/2/b2",
               bus.err, bus.roll_count, bus.disp_byte);
    end
    bus.hold_mode = 1'b0;
  endtask

  task automatic test_boundaries();
    bit busy_seen = 1'b0;
    apply_reset();
    bus.btn_roll = 1'b1;
    repeat (6) @(negedge CLK);
    bus.rnd_in = 8'h77; bus.rnd_valid = 1'b1;
    @(negedge CLK);
    bus.rnd_valid = 1'b0; bus.btn_roll = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.capture_pulse !== 1'b0 || bus.roll_count !== 8'd0) begin
      failures++;
      $display("FAIL coincident busy=%b pulse=%b cnt=%0d exp 1/0/0",
               bus.busy, bus.capture_pulse, bus.roll_count);
    end
    repeat (2) @(negedge CLK);
    bus.rnd_in = 8'h88; bus.rnd_valid = 1'b1;
    @(negedge CLK);
    bus.rnd_valid = 1'b0; bus.hold_mode = 1'b1; bus.sel_hist = 2'd0;
    #1;
    checks++;
    if (bus.capture_pulse !== 1'b1 || bus.roll_count !== 8'd1 || bus.disp_byte !== 8'h88) begin
      failures++;
      $display("FAIL next_strobe pulse=%b cnt=%0d disp=%h exp 1/1/88",
               bus.capture_pulse, bus.roll_count, bus.disp_byte);
    end
    bus.btn_roll = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.btn_roll = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen || bus.roll_count !== 8'd1) begin
      failures++;
      $display("FAIL lockout_press busy_seen=%b cnt=%0d exp 0/1", busy_seen, bus.roll_count);
    end
    bus.hold_mode = 1'b0;
  endtask

  task automatic test_count_wrap();
    apply_reset();
    for (int i = 0; i < 255; i++) roll(i[7:0]);
    checks++;
    if (bus.roll_count !== 8'd255) begin
      failures++;
      $display("FAIL count_255 got=%0d exp=255", bus.roll_count);
    end
    roll(8'hFF);
    bus.hold_mode = 1'b1; bus.sel_hist = 2'd1;
    #1;
    checks++;
    if (bus.roll_count !== 8'd0 || bus.disp_byte !== 8'hFE) begin
      failures++;
      $display("FAIL count_wrap cnt=%0d disp=%h exp 0/fe", bus.roll_count, bus.disp_byte);
    end
    bus.hold_mode = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    roll(8'hC3);
    bus.hold_mode = 1'b1; bus.sel_hist = 2'd0;
    press_wait_busy();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.disp_byte !== 8'h00 || bus.roll_count !== 8'd0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL midreset busy=%b disp=%h cnt=%0d err=%b exp 0/00/0/0",
               bus.busy, bus.disp_byte, bus.roll_count, bus.err);
    end
    @(negedge CLK);
    rst = 1'b1;
    bus.rnd_in = 8'hD4; bus.rnd_valid = 1'b1;
    @(negedge CLK);
    bus.rnd_valid = 1'b0;
    checks++;
    if (bus.roll_count !== 8'd0 || bus.capture_pulse !== 1'b0 || bus.disp_byte !== 8'h00 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL postreset_strobe cnt=%0d pulse=%b disp=%h busy=%b exp 0/0/00/0",
               bus.roll_count, bus.capture_pulse, bus.disp_byte, bus.busy);
    end
    bus.hold_mode = 1'b0;
    #1;
    checks++;
    if (bus.disp_byte !== 8'hD4) begin
      failures++;
      $display("FAIL postreset_live got=%h exp=d4", bus.disp_byte);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_roll();
    test_history_wrap();
    test_timeout();
    test_boundaries();
    test_count_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rng_roll_capture.md
# rng_roll_capture

Downstream consumer of the PRNG byte stream: on a debounced "roll" button press it captures the next fresh random byte into a 4-entry history buffer and presents either the live stream or a selected history entry to the 7-segment decode stage. Sits between the 16:8 LFSR mux output and the DEC_7SEG pair in the top level. Everything runs on the single CLK domain; the PRNG's new-byte event arrives as a one-cycle `rnd_valid` strobe.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16'd50_000: consecutive stable cycles needed to accept a button level change (≥1).
- TIMEOUT_CYCLES, 24'd10_000_000: max cycles to wait for `rnd_valid` after a roll request (≥1).
- LOCKOUT_CYCLES, 16'd1_000: dead time after a capture; roll requests are ignored during it (≥1).

Ports:
- CLK  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- rnd_in  input  8  current PRNG byte.
- rnd_valid  input  1  one-cycle strobe: rnd_in holds a new value this cycle.
- btn_roll  input  1  raw asynchronous push button, active-high.
- hold_mode  input  1  0 = live display, 1 = history display.
- sel_hist  input  2  history index, 0 = newest.
- disp_byte  output  8  byte to the 7-seg decoders.
- roll_count  output  8  number of successful captures, wraps 255→0.
- busy  output  1  high whenever FSM is not IDLE.
- err  output  1  sticky timeout flag.
- capture_pulse  output  1  one-cycle pulse after each capture.

## Operation
- Input conditioning: btn_roll → 2-flop synchronizer → debouncer. Debounce counter increments while synced level ≠ debounced level; it clears on any cycle they are equal. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears. A 0→1 debounced transition produces a one-cycle internal `roll_req`.
- FSM states: IDLE, WAIT_RND, LOCKOUT.
  - IDLE: roll_req → WAIT_RND; clear timeout counter.
  - WAIT_RND: on rnd_valid → write rnd_in to history[wr_ptr], wr_ptr+1 (mod 4), roll_count+1, err←0, capture_pulse←1, → LOCKOUT. Else, timeout counter reaches TIMEOUT_CYCLES → err←1, → IDLE, no write.
  - LOCKOUT: counts LOCKOUT_CYCLES cycles, then → IDLE.
- roll_req outside IDLE is discarded, not queued.
- rnd_valid in the same cycle as roll_req (still IDLE) is not captured. Only a strobe sampled while in WAIT_RND counts.
- Live register: updates to rnd_in on every rnd_valid, in all states.
- disp_byte: hold_mode=0 → live register. hold_mode=1 → history[(wr_ptr − 1 − sel_hist) mod 4], combinational from registered state. Unwritten entries read 0.

## Timing
- Reset (rst low, async): FSM=IDLE; all counters, wr_ptr, history, live register, synchronizer and debounced level = 0. All outputs 0.
- Button latency: btn_roll high and stable before edge E0. Debounced level flips at edge E0+1+DEBOUNCE_CYCLES. busy is high after edge E0+2+DEBOUNCE_CYCLES.
- Capture: rnd_valid sampled at edge N in WAIT_RND. After edge N, all of the following are visible together: history, roll_count, capture_pulse=1, state LOCKOUT. capture_pulse drops after N+1.
- LOCKOUT: busy stays high for exactly LOCKOUT_CYCLES cycles after N, then IDLE.
- Timeout: rnd_valid absent for TIMEOUT_CYCLES edges in WAIT_RND. After the last such edge: err=1 and busy=0.
- Reset asserted mid-operation returns everything to reset values immediately. No partial write survives.
- hold_mode and sel_hist changes reflect on disp_byte in the same cycle (no register).

## Test plan
Parameters for all tests: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8, LOCKOUT_CYCLES=3.
- Bounce rejection: btn_roll toggles every 2 cycles for 20 cycles, then stays 0 → busy never rises; roll_count=0.
- Clean roll: hold btn high; rnd_valid with rnd_in=8'hA5 three cycles after busy rises → capture_pulse for 1 cycle; roll_count=1; hold_mode=1/sel_hist=0 gives disp_byte=8'hA5; busy low exactly 3 cycles after capture.
- History wrap: five rolls capturing 11,22,33,44,55 → with hold_mode=1, sel_hist 0..3 read 55,44,33,22; roll_count=5.
- Timeout: roll, then no rnd_valid → err=1 after 8 WAIT_RND cycles, busy=0, history unchanged. A subsequent successful roll clears err.
- Boundary events: rnd_valid coincident with roll_req is not captured, the next strobe is. A press during LOCKOUT (released before IDLE) is ignored. 256 captures wrap roll_count to 0.
- Reset mid-WAIT_RND: rst low for 1 cycle → busy=0, disp_byte=0, roll_count=0, err=0; a rnd_valid right after the release is not captured.
